// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states, CTRL bit positions.
// Build option: define INTC_ROUND_ROBIN_EN for rotating priority; default is fixed priority (source 0 highest).
package intc_pkg;

    localparam logic [1:0] OFF_IE      = 2'd0;
    localparam logic [1:0] OFF_CTRL    = 2'd1;
    localparam logic [1:0] OFF_PENDING = 2'd2;
    localparam logic [1:0] OFF_VECTOR  = 2'd3;

    localparam int GIE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2
    } intc_state_t;

endpackage

// File: rtl/intc_priority_encoder.sv
// Combinational 8->3 priority encoder; search starts at 'start' and wraps, first set bit wins.
// Zero latency; no flow control (pure combinational).
module intc_priority_encoder (
    input  logic [7:0] req,
    input  logic [2:0] start,
    output logic [2:0] idx,
    output logic       valid
);

    logic       found;
    logic [2:0] pos;

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        found = 1'b0;
        pos   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            pos = start + 3'(k);
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: enables, priority select, irq/vector to CPU, one-cycle clear pulse on ack.
// Source-to-irq 1 cycle, ack-to-clear 1 cycle; no backpressure. Define INTC_ROUND_ROBIN_EN for rotating priority.
module interrupt_controller #(
    parameter logic [7:0] INTC_ADDRESS = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] irq_src,
    output logic [7:0] irq_clr,
    output logic       irq,
    output logic [2:0] irq_vector,
    input  logic       irq_ack
);

    import intc_pkg::*;

    logic [7:0]  ie;
    logic        gie;
    intc_state_t state;
    logic [7:0]  pending;
    logic [7:0]  offset;
    logic        in_window;
    logic [2:0]  winner;
    logic        winner_vld;
    logic [2:0]  search_start;

    assign pending   = irq_src & ie;
    assign offset    = address - INTC_ADDRESS;
    assign in_window = (offset < 8'd4);

`ifdef INTC_ROUND_ROBIN_EN
    logic [2:0] rr_ptr;
    assign search_start = rr_ptr;
`else
    assign search_start = 3'd0;
`endif

    intc_priority_encoder u_prio (
        .req   (pending),
        .start (search_start),
        .idx   (winner),
        .valid (winner_vld)
    );

    // Register file and read port; reads use pre-edge state, same as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie   <= 8'h00;
            gie  <= 1'b0;
            dout <= 8'h00;
        end else begin
            if (w_en && in_window) begin
                case (offset[1:0])
                    OFF_IE:   ie  <= din;
                    OFF_CTRL: gie <= din[GIE_BIT];
                    default: ;
                endcase
            end
            if (r_en) begin
                if (in_window) begin
                    case (offset[1:0])
                        OFF_IE:      dout <= ie;
                        OFF_CTRL:    dout <= {7'b0, gie};
                        OFF_PENDING: dout <= pending;
                        default:     dout <= {(state != IDLE), 4'b0, irq_vector};
                    endcase
                end else begin
                    dout <= 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_vector <= 3'd0;
            irq_clr    <= 8'h00;
`ifdef INTC_ROUND_ROBIN_EN
            rr_ptr     <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    irq_clr <= 8'h00;
                    if (gie && winner_vld) begin
                        state      <= REQ;
                        irq        <= 1'b1;
                        irq_vector <= winner;
                    end
                end
                REQ: begin
                    // Ack wins over a simultaneous withdraw so the serviced source is always cleared.
                    if (irq_ack) begin
                        state   <= CLR;
                        irq     <= 1'b0;
                        irq_clr <= 8'(1) << irq_vector;
                    end else if (!gie || !pending[irq_vector]) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                CLR: begin
                    state   <= IDLE;
                    irq_clr <= 8'h00;
`ifdef INTC_ROUND_ROBIN_EN
                    rr_ptr  <= irq_vector + 3'd1;
`endif
                end
                default: begin
                    state   <= IDLE;
                    irq     <= 1'b0;
                    irq_clr <= 8'h00;
                end
            endcase
        end
    end

endmodule
